// File: rtl/bellman_ford.sv
// bellman_ford: virtual-source Bellman-Ford relaxation over a dense adjacency matrix.
// Define BF_EARLY_EXIT_EN to stop as soon as a full pass makes no update.
module bellman_ford #(
    parameter int NODES        = 32,
    parameter int WEIGHT_WIDTH = 15,
    parameter int PRED_WIDTH   = 4,
    parameter int VERT_WIDTH   = 21
) (
    input  logic                  clk,
    input  logic                  bellman_reset,
    input  logic [VERT_WIDTH:0]   vertmat_q_a,
    input  logic [VERT_WIDTH:0]   vertmat_q_b,
    input  logic [WEIGHT_WIDTH:0] adjmat_q,
    output logic [PRED_WIDTH:0]   vertmat_addr_a,
    output logic [PRED_WIDTH:0]   vertmat_addr_b,
    output logic [VERT_WIDTH:0]   vertmat_data_b,
    output logic                  vertmat_we_b,
    output logic [PRED_WIDTH:0]   adjmat_row_addr,
    output logic [PRED_WIDTH:0]   adjmat_col_addr,
    output logic                  relax_overflow,
    output logic                  cycle_reset,
    output logic                  bellman_done
);
    localparam int PF = VERT_WIDTH - WEIGHT_WIDTH - 1;
    localparam int IW = PRED_WIDTH + 1;
    localparam logic [PRED_WIDTH:0] LAST_IDX  = IW'(NODES - 1);
    localparam logic [PRED_WIDTH:0] LAST_PASS = IW'((NODES > 1) ? NODES - 2 : 0);

    typedef enum logic [2:0] {INIT, READ, RELAX, NEXT, DONE} state_t;

    state_t              state_reg;
    logic [PRED_WIDTH:0] i_reg, j_reg, n_reg, pass_reg;
    logic                pass_updated_reg;
    logic                relax_overflow_reg, cycle_reset_reg, bellman_done_reg;

    function automatic logic [VERT_WIDTH:0] pack_vert(input logic [PRED_WIDTH:0] pred,
                                                      input logic [WEIGHT_WIDTH:0] weight);
        return {1'b0, PF'(pred), weight};
    endfunction

    // Relaxation datapath: one guard bit so the candidate sum can never wrap.
    logic signed [WEIGHT_WIDTH+1:0] e_x, svw_x, dvw_x, sum;
    logic                           do_update, sum_fits, last_pass;
    logic                           unused_bits;

    assign e_x   = {adjmat_q[WEIGHT_WIDTH], adjmat_q};
    assign svw_x = {vertmat_q_a[WEIGHT_WIDTH], vertmat_q_a[WEIGHT_WIDTH:0]};
    assign dvw_x = {vertmat_q_b[WEIGHT_WIDTH], vertmat_q_b[WEIGHT_WIDTH:0]};
    assign sum   = svw_x + e_x;
    assign sum_fits  = (sum[WEIGHT_WIDTH+1] == sum[WEIGHT_WIDTH]);
    assign do_update = (state_reg == RELAX) && (adjmat_q != '0) && (i_reg != j_reg) && (sum < dvw_x);
    assign unused_bits = ^{vertmat_q_a[VERT_WIDTH:WEIGHT_WIDTH+1], vertmat_q_b[VERT_WIDTH:WEIGHT_WIDTH+1]};

`ifdef BF_EARLY_EXIT_EN
    assign last_pass = (pass_reg == LAST_PASS) || !pass_updated_reg;
`else
    assign last_pass = (pass_reg == LAST_PASS);
`endif

    // Memory-side signals follow the current state so a RELAX write commits at the
    // end of the same cycle the read data arrives; reset gates them off at once.
    always_comb begin
        vertmat_addr_a  = '0;
        vertmat_addr_b  = '0;
        vertmat_data_b  = '0;
        vertmat_we_b    = 1'b0;
        adjmat_row_addr = '0;
        adjmat_col_addr = '0;
        if (!bellman_reset) begin
            unique case (state_reg)
                INIT: begin
                    vertmat_addr_b = n_reg;
                    vertmat_data_b = pack_vert(n_reg, '0);
                    vertmat_we_b   = 1'b1;
                end
                READ, RELAX, NEXT: begin
                    vertmat_addr_a  = i_reg;
                    vertmat_addr_b  = j_reg;
                    adjmat_row_addr = i_reg;
                    adjmat_col_addr = j_reg;
                    if (do_update && sum_fits) begin
                        vertmat_data_b = pack_vert(i_reg, sum[WEIGHT_WIDTH:0]);
                        vertmat_we_b   = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (bellman_reset) begin
            state_reg          <= INIT;
            i_reg              <= '0;
            j_reg              <= '0;
            n_reg              <= '0;
            pass_reg           <= '0;
            pass_updated_reg   <= 1'b0;
            relax_overflow_reg <= 1'b0;
            cycle_reset_reg    <= 1'b0;
            bellman_done_reg   <= 1'b0;
        end else begin
            cycle_reset_reg <= 1'b0;
            case (state_reg)
                INIT: begin
                    n_reg <= n_reg + 1'b1;
                    if (n_reg == LAST_IDX) begin
                        n_reg <= '0;
                        if (NODES == 1) begin
                            state_reg        <= DONE;
                            cycle_reset_reg  <= 1'b1;
                            bellman_done_reg <= 1'b1;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: state_reg <= RELAX;
                RELAX: begin
                    if (do_update) begin
                        if (sum_fits) pass_updated_reg   <= 1'b1;
                        else          relax_overflow_reg <= 1'b1;
                    end
                    state_reg <= NEXT;
                end
                NEXT: begin
                    state_reg <= READ;
                    if (j_reg == LAST_IDX) begin
                        j_reg <= '0;
                        if (i_reg == LAST_IDX) begin
                            i_reg <= '0;
                            if (last_pass) begin
                                state_reg        <= DONE;
                                cycle_reset_reg  <= 1'b1;
                                bellman_done_reg <= 1'b1;
                            end else begin
                                pass_reg         <= pass_reg + 1'b1;
                                pass_updated_reg <= 1'b0;
                            end
                        end else begin
                            i_reg <= i_reg + 1'b1;
                        end
                    end else begin
                        j_reg <= j_reg + 1'b1;
                    end
                end
                DONE: ;
                default: state_reg <= INIT;
            endcase
        end
    end

    assign relax_overflow = relax_overflow_reg;
    assign cycle_reset    = cycle_reset_reg;
    assign bellman_done   = bellman_done_reg;
endmodule

// File: tb/tb_bellman_ford.sv
// tb_bellman_ford: 4-node runs (empty, chain, negative cycle, overflow, reset mid-run)
// against synchronous RAM models; results are checked through a scoreboard queue.
module tb_bellman_ford;
    localparam int N  = 4;
    localparam int WW = 7;
    localparam int PW = 4;
    localparam int VW = 13;
`ifdef BF_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              bellman_reset = 1'b1;
    logic [VW:0]       vertmat_q_a, vertmat_q_b, vertmat_data_b;
    logic [WW:0]       adjmat_q;
    logic [PW:0]       vertmat_addr_a, vertmat_addr_b, adjmat_row_addr, adjmat_col_addr;
    logic              vertmat_we_b, relax_overflow, cycle_reset, bellman_done;
    logic              scrub = 1'b0;

    logic [VW:0]        vmem [0:31];
    logic signed [WW:0] adj  [0:31][0:31];

    typedef struct { int kind; int val; } exp_t;
    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;
    int   latency;

    always #5 clk = ~clk;

    bellman_ford #(.NODES(N), .WEIGHT_WIDTH(WW), .PRED_WIDTH(PW), .VERT_WIDTH(VW)) dut (
        .clk(clk), .bellman_reset(bellman_reset),
        .vertmat_q_a(vertmat_q_a), .vertmat_q_b(vertmat_q_b), .adjmat_q(adjmat_q),
        .vertmat_addr_a(vertmat_addr_a), .vertmat_addr_b(vertmat_addr_b),
        .vertmat_data_b(vertmat_data_b), .vertmat_we_b(vertmat_we_b),
        .adjmat_row_addr(adjmat_row_addr), .adjmat_col_addr(adjmat_col_addr),
        .relax_overflow(relax_overflow), .cycle_reset(cycle_reset), .bellman_done(bellman_done)
    );

    // Synchronous RAMs, read-first, one cycle of read latency.
    always @(posedge clk) begin
        vertmat_q_a <= vmem[vertmat_addr_a];
        vertmat_q_b <= vmem[vertmat_addr_b];
        adjmat_q    <= adj[adjmat_row_addr][adjmat_col_addr];
        if (scrub) begin
            for (int k = 0; k < 32; k++) vmem[k] <= 14'h3FFF;
        end else if (vertmat_we_b) begin
            vmem[vertmat_addr_b] <= vertmat_data_b;
        end
    end

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic int vw(input int pred, input int w);
        return (pred << 8) | (w & 8'hFF);
    endfunction

    function automatic void push(input int kind, input int val);
        exp_t e;
        e.kind = kind;
        e.val  = val;
        sb_q.push_back(e);
    endfunction

    task automatic hold_reset(input bit do_scrub);
        @(negedge clk);
        bellman_reset = 1'b1;
        scrub = do_scrub;
        @(negedge clk);
        scrub = 1'b0;
        @(negedge clk);
        check("rst_we_b", int'(vertmat_we_b), 0);
        check("rst_done", int'(bellman_done), 0);
        check("rst_ovf", int'(relax_overflow), 0);
        check("rst_addr_b", int'(vertmat_addr_b), 0);
        bellman_reset = 1'b0;
    endtask

    // Latency counted in rising edges after deassert; expected results then drain from the queue.
    task automatic wait_done(input int run);
        int obs;
        exp_t e;
        latency = -1;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk);
            #1;
            if (cycle_reset) begin
                latency = c;
                break;
            end
        end
        if (latency >= 0) begin
            check("done_with_pulse", int'(bellman_done), 1);
            @(posedge clk);
            #1;
            check("pulse_width", int'(cycle_reset), 0);
            check("done_held", int'(bellman_done), 1);
            check("done_addr_b", int'(vertmat_addr_b), 0);
        end
        $display("run %0d latency %0d overflow %0d", run, latency, relax_overflow);
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            case (e.kind)
                0:       obs = latency;
                1:       obs = int'(relax_overflow);
                default: obs = int'(vmem[e.kind - 2]);
            endcase
            check($sformatf("run%0d_item%0d", run, e.kind), obs, e.val);
        end
    endtask

    task automatic load_case(input int sc);
        for (int r = 0; r < 32; r++)
            for (int c = 0; c < 32; c++) adj[r][c] = '0;
        case (sc)
            0: begin
                push(0, EARLY ? 52 : 148); push(1, 0);
                for (int k = 0; k < N; k++) push(2 + k, vw(k, 0));
            end
            1: begin
                adj[0][1] = -8'sd2; adj[1][2] = -8'sd3;
                push(0, EARLY ? 100 : 148); push(1, 0);
                push(2, vw(0, 0)); push(3, vw(0, -2)); push(4, vw(1, -5)); push(5, vw(3, 0));
            end
            2: begin
                adj[0][1] = -8'sd3; adj[1][0] = 8'sd2;
                push(0, 148); push(1, 0);
                push(2, vw(1, -3)); push(3, vw(0, -5)); push(4, vw(2, 0)); push(5, vw(3, 0));
            end
            default: begin
                adj[0][1] = -8'sd100; adj[1][2] = -8'sd100;
                push(0, EARLY ? 100 : 148); push(1, 1);
                push(2, vw(0, 0)); push(3, vw(0, -100)); push(4, vw(2, 0)); push(5, vw(3, 0));
            end
        endcase
    endtask

    initial begin
        for (int sc = 0; sc < 4; sc++) begin
            load_case(sc);
            hold_reset(1'b1);
            wait_done(sc);
        end

        // Negative cycle again, aborted in the pass-1 RELAX of edge 0->1 (a write cycle).
        load_case(2);
        hold_reset(1'b1);
        for (int c = 1; c <= 56; c++) begin
            @(posedge clk);
        end
        #1;
        check("mid_we_before", int'(vertmat_we_b), 1);
        bellman_reset = 1'b1;
        #1;
        check("mid_we_b", int'(vertmat_we_b), 0);
        check("mid_done", int'(bellman_done), 0);
        hold_reset(1'b0);
        wait_done(4);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
